// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: default sizing, pending-counter width derivation and register index type
package hazard_scoreboard_pkg;
  localparam int NUM_REGS_D = 32;
  localparam int REG_AW_D = 5;
  localparam int MAX_INFL_D = 3;
  typedef logic [REG_AW_D-1:0] reg_idx_t;
  function automatic int cw_of(input int max_infl);
    return $clog2(max_infl + 1);
  endfunction
endpackage

// File: rtl/sb_reg_counter.sv
// sb_reg_counter: one register's pending-write counter with same-cycle retire bypass
module sb_reg_counter #(
  parameter int MAX_INFL = 3,
  parameter int CW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_full,
  output logic o_err
);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_eff;
  logic w_nz;
  assign w_nz = r_cnt != '0;
  // retire is applied before the issue-side view, and never drives the count below zero
  assign w_eff = r_cnt - CW'(i_dec && w_nz);
  assign o_zero = w_eff == '0;
  assign o_full = w_eff == CW'(MAX_INFL);
  assign o_err = (i_dec && !w_nz) || (i_inc && o_full);
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else r_cnt <= (i_inc && !o_full) ? w_eff + 1'b1 : w_eff;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-stage RAW/branch/full hazard unit built on per-register pending counters.
// Optional HAZARD_STALL_STATS_EN adds saturating raw/branch stall cycle counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int REG_AW = REG_AW_D,
  parameter int MAX_INFL = MAX_INFL_D,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_rs1_en,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic              issue_rs2_en,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_rd_en,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_branch,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              br_resolve,
  input  logic              flush,
  output logic              stall,
  output logic              issue_fire,
  output logic              sb_error
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]       raw_stall_cnt,
  output logic [31:0]       br_stall_cnt
`endif
);
  localparam int CW = cw_of(MAX_INFL);
  logic [NUM_REGS-1:0] w_inc, w_dec, w_zero, w_full, w_err;
  logic w_raw, w_full_rd, r_br, r_err;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam bit T = !(R0_ZERO && g == 0);
    assign w_inc[g] = T && issue_fire && issue_rd_en && issue_rd == REG_AW'(g);
    assign w_dec[g] = T && wb_valid && wb_rd == REG_AW'(g);
    sb_reg_counter #(.MAX_INFL(MAX_INFL), .CW(CW)) u_cnt (
      .clk(clk), .rst(rst), .i_clr(flush), .i_inc(w_inc[g]), .i_dec(w_dec[g]),
      .o_zero(w_zero[g]), .o_full(w_full[g]), .o_err(w_err[g])
    );
  end
  // an untracked r0 never leaves zero, so it can never raise RAW
  assign w_raw = (issue_rs1_en && !w_zero[issue_rs1]) || (issue_rs2_en && !w_zero[issue_rs2]);
  assign w_full_rd = issue_rd_en && w_full[issue_rd];
  assign stall = issue_valid && (w_raw || r_br || w_full_rd);
  assign issue_fire = issue_valid && !stall;
  assign sb_error = r_err;
  always_ff @(posedge clk)
    if (rst) begin
      r_br <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_br <= !flush && ((issue_fire && issue_branch) || (r_br && !br_resolve));
      r_err <= r_err || (|w_err) || (br_resolve && !r_br);
    end
`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      raw_stall_cnt <= '0;
      br_stall_cnt <= '0;
    end else begin
      if (issue_valid && w_raw && !(&raw_stall_cnt)) raw_stall_cnt <= raw_stall_cnt + 32'd1;
      if (issue_valid && r_br && !w_raw && !(&br_stall_cnt)) br_stall_cnt <= br_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_hazard_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 0, issue_rs1_en = 0, issue_rs2_en = 0, issue_rd_en = 0, issue_branch = 0;
  logic [4:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wb_rd = 0;
  logic wb_valid = 0, br_resolve = 0, flush = 0;
  logic stall, issue_fire, sb_error;
  int checks = 0, errors = 0;
  typedef struct {
    string n;
    logic stall, fire, err;
  } exp_t;
  typedef struct {
    string n;
    logic [31:0] raw, br;
  } stat_t;
  exp_t q[$];
  stat_t sq[$];
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] raw_stall_cnt, br_stall_cnt;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_rs1_en(issue_rs1_en), .issue_rs1(issue_rs1),
    .issue_rs2_en(issue_rs2_en), .issue_rs2(issue_rs2),
    .issue_rd_en(issue_rd_en), .issue_rd(issue_rd), .issue_branch(issue_branch),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_resolve(br_resolve), .flush(flush),
    .stall(stall), .issue_fire(issue_fire), .sb_error(sb_error)
`ifdef HAZARD_STALL_STATS_EN
    , .raw_stall_cnt(raw_stall_cnt), .br_stall_cnt(br_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({stall, issue_fire, sb_error} !== {e.stall, e.fire, e.err}) begin
        errors++;
        $display("FAIL %s: got stall=%b fire=%b err=%b, expected stall=%b fire=%b err=%b",
                 e.n, stall, issue_fire, sb_error, e.stall, e.fire, e.err);
      end
    end
    while (sq.size() != 0) begin
      stat_t s;
      s = sq.pop_front();
`ifdef HAZARD_STALL_STATS_EN
      checks++;
      if (raw_stall_cnt !== s.raw || br_stall_cnt !== s.br) begin
        errors++;
        $display("FAIL %s: got raw=%0d br=%0d, expected raw=%0d br=%0d",
                 s.n, raw_stall_cnt, br_stall_cnt, s.raw, s.br);
      end
`endif
    end
  end

  task automatic cyc(input string n, input logic v, r1e, input logic [4:0] r1, input logic r2e,
                     input logic [4:0] r2, input logic rde, input logic [4:0] rd, input logic br,
                     input logic wbv, input logic [4:0] wr, input logic res, fl, rs, es, ee);
    @(posedge clk);
    #1;
    rst = rs; issue_valid = v; issue_rs1_en = r1e; issue_rs1 = r1; issue_rs2_en = r2e; issue_rs2 = r2;
    issue_rd_en = rde; issue_rd = rd; issue_branch = br; wb_valid = wbv; wb_rd = wr;
    br_resolve = res; flush = fl;
    q.push_back('{n, es, v && !es, ee});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    cyc("reset",        0,0,0,0,0,0,0,0,0,0,0,0,1,0,0);
    // single write then dependent read, cleared by same-cycle write-back
    cyc("t1_issue_r5",  1,0,0,0,0,1,5,0,0,0,0,0,0,0,0);
    cyc("t1_raw_r5",    1,1,5,0,0,0,0,0,0,0,0,0,0,1,0);
    cyc("t1_wb_bypass", 1,1,5,0,0,0,0,0,1,5,0,0,0,0,0);
    for (int i = 0; i < 3; i++) cyc("t2_fill", 1,0,0,0,0,1,5,0,0,0,0,0,0,0,0);
    cyc("t2_full",      1,0,0,0,0,1,5,0,0,0,0,0,0,1,0);
    cyc("t2_full_wb",   1,0,0,0,0,1,5,0,1,5,0,0,0,0,0);
    for (int i = 0; i < 3; i++) cyc("t2_drain", 0,0,0,0,0,0,0,0,1,5,0,0,0,0,0);
    cyc("t2_empty",     1,1,5,0,0,0,0,0,0,0,0,0,0,0,0);
    // branch blocks all issue until the cycle after resolve
    cyc("t3_branch",    1,0,0,0,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 2; i++) cyc("t3_br_stall", 1,1,1,0,0,0,0,0,0,0,0,0,0,1,0);
    cyc("t3_resolve",   1,1,1,0,0,0,0,0,0,0,1,0,0,1,0);
    cyc("t3_after_res", 1,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 2; i++) cyc("t4_r3", 1,0,0,0,0,1,3,0,0,0,0,0,0,0,0);
    cyc("t4_branch",    1,0,0,0,0,0,0,1,0,0,0,0,0,0,0);
    cyc("t4_flush",     1,1,3,0,0,0,0,0,0,0,0,1,0,1,0);
    cyc("t4_post",      1,1,3,1,3,0,0,0,0,0,0,0,0,0,0);
    cyc("t4_fire_fl",   1,0,0,0,0,1,7,0,0,0,0,1,0,0,0);
    cyc("t4_discard",   1,1,7,0,0,0,0,0,0,0,0,0,0,0,0);
    // r0 never tracked; write-back with nothing pending is sticky error
    cyc("t5_issue_r0",  1,0,0,0,0,1,0,0,0,0,0,0,0,0,0);
    cyc("t5_read_r0",   1,1,0,1,0,0,0,0,0,0,0,0,0,0,0);
    cyc("t5_bad_wb",    0,0,0,0,0,0,0,0,1,7,0,0,0,0,0);
    cyc("t5_err_set",   0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    cyc("t5_err_stick", 1,0,0,0,0,1,9,0,0,0,0,0,0,0,1);
    cyc("rst_mid",      1,0,0,0,0,1,4,0,0,0,0,0,1,0,1);
    cyc("rst_clear",    1,1,9,1,4,0,0,0,0,0,0,0,0,0,0);
    cyc("bad_resolve",  0,0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    cyc("bad_res_err",  0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    // four raw stall cycles then two branch stall cycles
    cyc("t6_issue_r2",  1,0,0,0,0,1,2,0,0,0,0,0,0,0,1);
    for (int i = 0; i < 4; i++) cyc("t6_raw", 1,1,2,0,0,0,0,0,0,0,0,0,0,1,1);
    cyc("t6_wb",        1,1,2,0,0,0,0,0,1,2,0,0,0,0,1);
    cyc("t6_branch",    1,0,0,0,0,0,0,1,0,0,0,0,0,0,1);
    cyc("t6_br",        1,1,1,0,0,0,0,0,0,0,0,0,0,1,1);
    cyc("t6_br_res",    1,1,1,0,0,0,0,0,0,0,1,0,0,1,1);
    cyc("t6_go",        1,1,1,0,0,0,0,0,0,0,0,0,0,0,1);
    sq.push_back('{"t6_stats", 32'd4, 32'd2});
    cyc("idle",         0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
